// File: rtl/context_stack.sv
// Purpose : saves/restores an NWORDS-word context frame to data memory over the shared bus, with stack bounds checking.
// Latency : op_done NWORDS+1 cycles after op_start with bus_grant held high, +1 per wait cycle; 1 cycle on a bounds error.
// Backpr. : bus_grant low stalls the current word indefinitely with address/data/strobes held; op_start ignored while busy.
// Ports   : clk/rst (async active-low); op_start/op_push/busy/op_done/op_err control handshake with the CPU;
//           sp_in/sp_out/sp_we stack pointer exchange; push_data/pop_data packed frames (word i at [i*DATA_W +: DATA_W]);
//           bus_req/bus_grant/mem_addr/mem_wr/mem_rd/mem_wdata/mem_rdata data-memory bus side.
module context_stack #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                NWORDS   = 2,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 8'h80,
    parameter logic [ADDR_W-1:0] SP_EMPTY = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_start,
    input  logic                     op_push,
    output logic                     busy,
    output logic                     op_done,
    output logic                     op_err,
    input  logic [ADDR_W-1:0]        sp_in,
    output logic [ADDR_W-1:0]        sp_out,
    output logic                     sp_we,
    input  logic [NWORDS*DATA_W-1:0] push_data,
    output logic [NWORDS*DATA_W-1:0] pop_data,
    output logic                     bus_req,
    input  logic                     bus_grant,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_wr,
    output logic                     mem_rd,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int                FRAME_W = NWORDS * DATA_W;
    localparam int                CNT_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(NWORDS - 1);
    localparam logic [ADDR_W:0]   NW_EXT  = (ADDR_W + 1)'(NWORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                push_q, push_d;
    logic [ADDR_W-1:0]   sp_lat_q, sp_lat_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [ADDR_W-1:0]   sp_out_q, sp_out_d;
    logic [FRAME_W-1:0]  pop_q, pop_d;

    // Bounds check in ADDR_W+1 bits so neither direction can wrap around.
    logic [ADDR_W:0] sp_ext;
    logic            push_ok, pop_ok;

    assign sp_ext  = {1'b0, sp_in};
    assign push_ok = (sp_ext >= NW_EXT) && ((sp_ext - NW_EXT) >= {1'b0, SP_LIMIT});
    assign pop_ok  = (sp_ext + NW_EXT) <= {1'b0, SP_EMPTY};

    // Push walks words 0..N-1 downwards from SP-1; pop walks words N-1..0
    // upwards from SP, so the counter maps to a different frame word per direction.
    logic [CNT_W-1:0]  word_idx;
    logic [ADDR_W-1:0] xfer_addr;

    assign word_idx  = push_q ? cnt_q : (LAST - cnt_q);
    assign xfer_addr = push_q ? (sp_lat_q - ADDR_W'(1) - ADDR_W'(cnt_q))
                              : (sp_lat_q + ADDR_W'(cnt_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            push_q   <= 1'b0;
            sp_lat_q <= '0;
            frame_q  <= '0;
            sp_out_q <= '0;
            pop_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            push_q   <= push_d;
            sp_lat_q <= sp_lat_d;
            frame_q  <= frame_d;
            sp_out_q <= sp_out_d;
            pop_q    <= pop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push_d   = push_q;
        sp_lat_d = sp_lat_q;
        frame_d  = frame_q;
        sp_out_d = sp_out_q;
        pop_d    = pop_q;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    if (op_push ? push_ok : pop_ok) begin
                        push_d   = op_push;
                        sp_lat_d = sp_in;
                        frame_d  = push_data;
                        sp_out_d = op_push ? (sp_in - ADDR_W'(NWORDS))
                                           : (sp_in + ADDR_W'(NWORDS));
                        cnt_d    = '0;
                        state_d  = ST_XFER;
                    end else begin
                        state_d  = ST_ERR;
                    end
                end
            end
            ST_XFER: begin
                if (bus_grant) begin
                    if (!push_q) begin
                        pop_d[int'(word_idx)*DATA_W +: DATA_W] = mem_rdata;
                    end
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign op_done   = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign op_err    = (state_q == ST_ERR);
    assign sp_we     = (state_q == ST_DONE);
    assign sp_out    = sp_out_q;
    assign pop_data  = pop_q;
    assign bus_req   = (state_q == ST_XFER);
    assign mem_wr    = bus_req && push_q;
    assign mem_rd    = bus_req && !push_q;
    assign mem_addr  = bus_req ? xfer_addr : '0;
    assign mem_wdata = mem_wr ? frame_q[int'(word_idx)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_context_stack.sv
module tb_context_stack;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: defaults (NWORDS=2, DATA_W=8) ----------------
    logic        a_start, a_push, a_busy, a_done, a_err, a_we, a_req, a_grant;
    logic        a_wr, a_rd;
    logic [7:0]  a_sp_in, a_sp_out, a_addr, a_wdata, a_rdata;
    logic [15:0] a_push_data, a_pop_data;
    logic [7:0]  mem_a [256];

    context_stack u_a (
        .clk(clk), .rst(rst), .op_start(a_start), .op_push(a_push),
        .busy(a_busy), .op_done(a_done), .op_err(a_err),
        .sp_in(a_sp_in), .sp_out(a_sp_out), .sp_we(a_we),
        .push_data(a_push_data), .pop_data(a_pop_data),
        .bus_req(a_req), .bus_grant(a_grant), .mem_addr(a_addr),
        .mem_wr(a_wr), .mem_rd(a_rd), .mem_wdata(a_wdata), .mem_rdata(a_rdata)
    );

    always @(posedge clk) if (a_req && a_grant && a_wr) mem_a[a_addr] <= a_wdata;
    assign a_rdata = mem_a[a_addr];

    // ---------------- instance B: NWORDS=4, DATA_W=16 ----------------
    logic        b_start, b_push, b_busy, b_done, b_err, b_we, b_req, b_grant;
    logic        b_wr, b_rd;
    logic [7:0]  b_sp_in, b_sp_out, b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [63:0] b_push_data, b_pop_data;
    logic [15:0] mem_b [256];

    context_stack #(.DATA_W(16), .ADDR_W(8), .NWORDS(4)) u_b (
        .clk(clk), .rst(rst), .op_start(b_start), .op_push(b_push),
        .busy(b_busy), .op_done(b_done), .op_err(b_err),
        .sp_in(b_sp_in), .sp_out(b_sp_out), .sp_we(b_we),
        .push_data(b_push_data), .pop_data(b_pop_data),
        .bus_req(b_req), .bus_grant(b_grant), .mem_addr(b_addr),
        .mem_wr(b_wr), .mem_rd(b_rd), .mem_wdata(b_wdata), .mem_rdata(b_rdata)
    );

    always @(posedge clk) if (b_req && b_grant && b_wr) mem_b[b_addr] <= b_wdata;
    assign b_rdata = mem_b[b_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          push;
        logic [7:0]  sp;
        logic [15:0] data;
        int          stall;     // wait cycles per word before grant
        bit          exp_err;
        int          exp_done;  // cycle of op_done, op_start cycle = 0
        logic [7:0]  exp_sp;    // sp_out after the op
        logic [7:0]  exp_a0;
        logic [7:0]  exp_a1;
        logic [15:0] exp_pop;
    } vec_t;

    // Runs one op on instance A with the bench supplying grants, then compares.
    task automatic run_a(input string tag, input vec_t v);
        int         cyc, wc, nacc;
        bit         done, stable, saw_req;
        logic       err, we, ref_wr;
        logic [7:0] spo, ref_addr, ref_wd;
        logic [7:0] addrs [2];
        addrs[0] = 8'h00; addrs[1] = 8'h00;
        err = 1'b0; we = 1'b0; spo = 8'h00;
        ref_addr = 8'h00; ref_wd = 8'h00; ref_wr = 1'b0;
        a_push = v.push; a_sp_in = v.sp; a_push_data = v.data;
        a_start = 1'b1; a_grant = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 1; wc = 0; nacc = 0; done = 0; stable = 1; saw_req = 0;
        while (!done && cyc < 40) begin
            if (a_req) begin
                saw_req = 1;
                if (wc == 0) begin
                    ref_addr = a_addr; ref_wd = a_wdata; ref_wr = a_wr;
                end else if (a_addr !== ref_addr || a_wdata !== ref_wd || a_wr !== ref_wr) begin
                    stable = 0;
                end
                a_grant = (wc == v.stall);
                if (a_grant) begin
                    if (nacc < 2) addrs[nacc] = a_addr;
                    nacc++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                a_grant = 1'b0;
            end
            if (a_done) begin
                done = 1; err = a_err; we = a_we; spo = a_sp_out;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        a_grant = 1'b0;
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_done_cycle"}, 64'(cyc), 64'(v.exp_done));
        check({tag, "_err"}, 64'(err), 64'(v.exp_err));
        check({tag, "_sp_we"}, 64'(we), 64'(!v.exp_err));
        check({tag, "_sp_out"}, 64'(spo), 64'(v.exp_sp));
        if (v.exp_err) begin
            check({tag, "_no_bus_req"}, 64'(saw_req), 64'd0);
        end else begin
            check({tag, "_addr0"}, 64'(addrs[0]), 64'(v.exp_a0));
            check({tag, "_addr1"}, 64'(addrs[1]), 64'(v.exp_a1));
            if (v.push) begin
                check({tag, "_mem_w0"}, 64'(mem_a[v.exp_a0]), 64'(v.data[7:0]));
                check({tag, "_mem_w1"}, 64'(mem_a[v.exp_a1]), 64'(v.data[15:8]));
            end else begin
                check({tag, "_pop_data"}, 64'(a_pop_data), 64'(v.exp_pop));
            end
            if (v.stall > 0) check({tag, "_stall_stable"}, 64'(stable), 64'd1);
        end
    endtask

    // Instance B op with grant tied high.
    task automatic run_b(input string tag, input bit push, input logic [7:0] sp,
                         input logic [63:0] data, input logic [7:0] exp_sp,
                         input logic [31:0] exp_addrs, input logic [63:0] exp_pop);
        int         cyc, nacc;
        bit         done;
        logic       we;
        logic [7:0] spo;
        logic [31:0] addrs;
        addrs = 32'h0; we = 1'b0; spo = 8'h00;
        b_push = push; b_sp_in = sp; b_push_data = data; b_start = 1'b1; b_grant = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 1; nacc = 0; done = 0;
        while (!done && cyc < 40) begin
            if (b_req) begin
                if (nacc < 4) addrs[8*nacc +: 8] = b_addr;
                nacc++;
            end
            if (b_done) begin
                done = 1; we = b_we; spo = b_sp_out;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_done_cycle"}, 64'(cyc), 64'd5);
        check({tag, "_sp_we"}, 64'(we), 64'd1);
        check({tag, "_sp_out"}, 64'(spo), 64'(exp_sp));
        check({tag, "_addrs"}, 64'(addrs), 64'(exp_addrs));
        if (!push) check({tag, "_pop_data"}, b_pop_data, exp_pop);
    endtask

    vec_t tbl [8];
    vec_t after_rst;
    bit   spurious_done;

    initial begin
        n_chk = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 16'h0000;
        end
        a_start = 0; a_push = 0; a_sp_in = 0; a_push_data = 0; a_grant = 0;
        b_start = 0; b_push = 0; b_sp_in = 0; b_push_data = 0; b_grant = 0;
        rst = 1'b0;

        //            push sp     data      stl err done sp     a0     a1     pop
        tbl[0] = '{1'b1, 8'hF0, 16'hA53C, 0, 1'b0, 3, 8'hEE, 8'hEF, 8'hEE, 16'h0000};
        tbl[1] = '{1'b0, 8'hEE, 16'h0000, 0, 1'b0, 3, 8'hF0, 8'hEE, 8'hEF, 16'hA53C};
        tbl[2] = '{1'b1, 8'hF0, 16'hA53C, 3, 1'b0, 9, 8'hEE, 8'hEF, 8'hEE, 16'h0000};
        tbl[3] = '{1'b1, 8'h81, 16'h1111, 0, 1'b1, 1, 8'hEE, 8'h00, 8'h00, 16'h0000};
        tbl[4] = '{1'b0, 8'hFE, 16'h0000, 0, 1'b1, 1, 8'hEE, 8'h00, 8'h00, 16'h0000};
        tbl[5] = '{1'b1, 8'h80, 16'h2222, 0, 1'b1, 1, 8'hEE, 8'h00, 8'h00, 16'h0000};
        tbl[6] = '{1'b1, 8'h82, 16'h5A69, 0, 1'b0, 3, 8'h80, 8'h81, 8'h80, 16'h0000};
        tbl[7] = '{1'b0, 8'h80, 16'h0000, 0, 1'b0, 3, 8'h82, 8'h80, 8'h81, 16'h5A69};

        #12;
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_bus_req", 64'(a_req), 64'd0);
        check("rst_op_done", 64'(a_done), 64'd0);
        check("rst_sp_out", 64'(a_sp_out), 64'd0);
        check("rst_pop_data", 64'(a_pop_data), 64'd0);
        check("rst_mem_addr", 64'(a_addr), 64'd0);
        check("rst_mem_wdata", 64'(a_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_a($sformatf("v%0d", i), tbl[i]);
            @(negedge clk);
        end

        // Reset after the first word of a push has been granted.
        a_push = 1'b1; a_sp_in = 8'hF0; a_push_data = 16'h1122; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_grant = 1'b1;
        @(negedge clk);
        check("abort_req_before", 64'(a_req), 64'd1);
        a_grant = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_bus_req", 64'(a_req), 64'd0);
        check("abort_busy", 64'(a_busy), 64'd0);
        check("abort_mem_wr", 64'(a_wr), 64'd0);
        spurious_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_done) spurious_done = 1'b1;
        end
        check("abort_no_done", 64'(spurious_done), 64'd0);
        check("abort_partial_write", 64'(mem_a[8'hEF]), 64'h22);
        rst = 1'b1;
        @(negedge clk);
        after_rst = '{1'b1, 8'hF0, 16'h3344, 0, 1'b0, 3, 8'hEE, 8'hEF, 8'hEE, 16'h0000};
        run_a("post_rst", after_rst);
        @(negedge clk);

        // Four 16-bit words round-trip.
        run_b("b_push", 1'b1, 8'hC0, 64'h4444_3333_2222_1111, 8'hBC, 32'hBC_BD_BE_BF, 64'h0);
        @(negedge clk);
        run_b("b_pop", 1'b0, 8'hBC, 64'h0, 8'hC0, 32'hBF_BE_BD_BC, 64'h4444_3333_2222_1111);
        b_grant = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/context_stack.md
Name: context_stack

Overview:
- Parametrised stack engine that saves or restores an NWORDS-word context frame (PC, flags, extra registers) in data memory through the shared bus.
- Sits between the CPU control unit and the data-memory bus arbiter, replacing the fixed 2-word push/pop controller.
- Adds configurable word count and data width, stack-bounds checking with overflow/underflow error reporting, input latching, and a single done/error pulse.

Parameters:
- DATA_W, 8: memory data width and width of each context word.
- ADDR_W, 8: data-memory address and SP width.
- NWORDS, 2: words per frame, legal range 1..8.
- SP_LIMIT, 8'h80: lowest usable stack address.
- SP_EMPTY, 8'hFF: SP value when the stack is empty; highest usable address is SP_EMPTY-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_start  in  1  start request, sampled only in IDLE.
- op_push  in  1  1 = push, 0 = pop; sampled with op_start.
- busy  out  1  high in any state other than IDLE.
- op_done  out  1  one-cycle pulse at end of operation (success or error).
- op_err  out  1  one-cycle pulse with op_done when the bounds check fails.
- sp_in  in  ADDR_W  current SP; sampled at op_start.
- sp_out  out  ADDR_W  new SP; registered at op_start.
- sp_we  out  1  one-cycle pulse with successful op_done; CPU loads sp_out.
- push_data  in  NWORDS*DATA_W  frame to save; word i is bits [i*DATA_W +: DATA_W]; latched at op_start.
- pop_data  out  NWORDS*DATA_W  restored frame, same packing; holds until overwritten by a later pop.
- bus_req  out  1  bus request, high throughout XFER.
- bus_grant  in  1  transfer of the current word completes in this cycle.
- mem_addr  out  ADDR_W  word address, valid while bus_req is high.
- mem_wr  out  1  write strobe (push, XFER).
- mem_rd  out  1  read strobe (pop, XFER).
- mem_wdata  out  DATA_W  write data; 0 when mem_wr is low.
- mem_rdata  in  DATA_W  read data; sampled when bus_grant is high.

Behaviour:
- Reset (rst=0, immediate, asynchronous): state IDLE. All outputs 0: sp_out, pop_data, bus_req, strobes, pulses, mem_addr, mem_wdata. Word counter 0.
- Reset during an operation aborts it. bus_req drops immediately, no op_done is issued, and partially written memory is not undone.
- Stack is descending; SP points at the last pushed word. Word i of a frame lives at SP_old-1-i on push, equal to SP_new+NWORDS-1-i.
- Push: words are transferred in order i=0..NWORDS-1. mem_addr = sp_in_latched-1-cnt. New SP = sp_in-NWORDS.
- Pop: words are transferred in order i=NWORDS-1..0. mem_addr = sp_in_latched+(NWORDS-1-i). New SP = sp_in+NWORDS.
- Bounds check uses ADDR_W+1 bit unsigned arithmetic, with no wrap.
  - Push is legal iff sp_in-NWORDS >= SP_LIMIT.
  - Pop is legal iff sp_in+NWORDS <= SP_EMPTY.
- IDLE:
  - op_start=1 and legal: latch inputs, register sp_out, cnt=0, go to XFER.
  - op_start=1 and illegal: go to ERR. sp_out is unchanged and no bus activity occurs.
  - op_start=0: stay in IDLE.
- XFER: bus_req=1.
  - bus_grant=0: hold address, data and strobes stable and wait indefinitely.
  - bus_grant=1 (push): the word completes.
  - bus_grant=1 (pop): the addressed pop_data word is loaded from mem_rdata.
  - After a granted word: if cnt==NWORDS-1, go to DONE; otherwise cnt+1.
- DONE: op_done=1, sp_we=1 for one cycle, then IDLE.
- ERR: op_done=1, op_err=1 for one cycle, sp_we=0, then IDLE.
- op_start while busy is ignored. A new op may start in the cycle after op_done.
- Latency with bus_grant held high: op_done occurs NWORDS+1 cycles after the op_start cycle. For an error, op_done occurs 1 cycle after op_start.
- Each wait cycle (bus_grant=0) adds exactly one cycle of latency.
- pop_data words that were not reached (abort by reset) keep their previous values.

Test Plan:
- Push, defaults: sp_in=8'hF0, push_data={8'hA5,8'h3C}, grant tied 1. Required: cycle 1 writes [EF]=3C, cycle 2 writes [EE]=A5. op_done and sp_we occur at cycle 3 with sp_out=EE.
- Pop after the push: sp_in=8'hEE, grant tied 1. Required: reads [EE] then [EF], pop_data=16'hA53C, sp_out=F0, op_done at cycle 3.
- Grant stalls: same push with bus_grant low 3 cycles per word. Required: mem_addr, mem_wdata and mem_wr stay stable while waiting; op_done at cycle 9.
- Bounds:
  - Push with sp_in=8'h81, NWORDS=2: op_err with op_done at cycle 1, no bus_req, no sp_we.
  - Pop with sp_in=8'hFE: op_err.
  - Push with sp_in=8'h82: succeeds with sp_out=80.
- NWORDS=4, DATA_W=16: push then pop of 4 distinct words round-trips exactly. Addresses are SP-1..SP-4, and sp_out returns to the original SP.
- Reset mid-XFER: assert rst=0 after the first word granted. Required: bus_req=0 in the same cycle, no op_done, busy=0. A following op_start begins normally.
